ball_motion: RTL and testbench
==============================

// Module: ball_motion
// PURPOSE
//  Pong ball position engine; consumes the slow divided clock from the ball clock divider.
//  Treats that clock as data: synchronises it, edge-detects it, advances the ball one step per rising edge.
//  Handles wall and paddle bounces, serve, and per-side miss detection.
//  Feeds ball_x/ball_y to the VGA pixel renderer and miss pulses to the score logic.
// PARAMETERS
//  H_ACTIVE     640  visible width, pixels
//  V_ACTIVE     480  visible height, pixels
//  BALL_SIZE    8    ball square edge, pixels
//  PADDLE_W     8    paddle width, pixels
//  PADDLE_H     64   paddle height, pixels
//  PADDLE_L_X   16   left paddle left edge x
//  PADDLE_R_X   616  right paddle left edge x
//  STEP         1    pixels moved per axis per step
//  SERVE_TICKS  60   steps held in MISS before recentre
// PORTS
//  clock_in    in   1   system clock, single domain
//  reset       in   1   asynchronous, active-high; all state cleared
//  ball_clk    in   1   divided clock from divider, sampled as data
//  serve       in   1   level; starts ball from IDLE
//  paddle_l_y  in   10  left paddle top y
//  paddle_r_y  in   10  right paddle top y
//  ball_x      out  10  ball top-left x
//  ball_y      out  10  ball top-left y
//  ball_active out  1   1 while in MOVE
//  miss_l      out  1   1-cycle pulse: ball passed left paddle
//  miss_r      out  1   1-cycle pulse: ball passed right paddle
// BEHAVIOUR
//  Reset: ball_x=(H_ACTIVE-BALL_SIZE)/2=316, ball_y=(V_ACTIVE-BALL_SIZE)/2=236; dx=+ (right), dy=+ (down).
//   Also: state=IDLE, ball_active=0, miss_l=miss_r=0, sync flops=0, step counter=0.
//  Step: ball_clk -> 2 flops -> edge reg; step=1 for exactly one clock_in cycle.
//   step asserts on the 3rd clock_in edge after ball_clk rises.
//  FSM:
//   IDLE: ball held at centre; serve=1 -> MOVE on next edge.
//   MOVE: ball_active=1; on each step, update position as below; serve ignored.
//   MISS: ball frozen; count SERVE_TICKS steps; then recentre, keep dx, -> IDLE.
//  Step update, all compares in 11-bit unsigned (no wrap):
//   Top wall: dy=- and y<STEP -> y=0, dy=+.
//   Bottom wall: dy=+ and y+BALL_SIZE+STEP>=V_ACTIVE -> y=V_ACTIVE-BALL_SIZE, dy=-.
//   Else y+=/-STEP.
//   Left paddle hit, all three true:
//    - dx=-
//    - x>=PADDLE_L_X+PADDLE_W and x-STEP<=PADDLE_L_X+PADDLE_W
//    - y+BALL_SIZE>paddle_l_y and y<paddle_l_y+PADDLE_H (current y)
//    -> x=PADDLE_L_X+PADDLE_W, dx=+.
//   Right paddle hit: mirror; face = PADDLE_R_X-BALL_SIZE -> x=face, dx=-.
//   Left miss: dx=- and x<STEP, no hit -> x=0, miss_l pulse, -> MISS.
//   Right miss: dx=+ and x+BALL_SIZE+STEP>=H_ACTIVE, no hit -> x=H_ACTIVE-BALL_SIZE, miss_r pulse, -> MISS.
//   Else x+=/-STEP.
//  Miss pulse is registered, coincident with the state change to MISS.
//  Simultaneous events: wall and paddle/miss in the same step both apply.
//   Paddle hit has priority over miss.
//  Paddle inputs are sampled only on the step cycle; changes between steps have no effect.
//  Reset mid-MOVE/MISS: async return to reset values; no miss pulse emitted.
//  Sustained ball_clk=1 gives one step only.
// STRUCTURE
//  pong_defs.vh: H_ACTIVE/V_ACTIVE defaults, FSM encodings (IDLE=0, MOVE=1, MISS=2), coordinate width 10.
//  Sub-module tick_sync: 2-flop synchroniser + rising-edge detect -> step.
//  The rest is one FSM plus a datapath always block.
// TESTING (bench: ball_clk = clock_in/8, SERVE_TICKS=4, paddles at y=200)
//  Reset, serve=0 for 100 cycles -> ball stays at (316,236), ball_active=0, no miss pulses.
//  serve=1 one cycle, 3 steps -> (319,239), ball_active=1; step lag 3 cycles after each ball_clk rise.
//  Preload y=471, dy=+ -> next step y=472, dy=-; step after -> y=471.
//  Ball at x=25, dx=-, y=210, paddle_l_y=200 -> x=24, dx=+; no miss_l.
//  Same with paddle_l_y=300 -> reaches x=0, miss_l high one cycle, MISS.
//   After 4 steps -> back at (316,236), IDLE.
//  Assert reset mid-MOVE at (400,100) -> immediately (316,236), IDLE, outputs 0.
//   ball_clk stuck high -> exactly one step.

Source files
------------

// File: rtl/ball_motion_pkg.sv
// Shared geometry, coordinate types and FSM encoding for the pong ball engine.
// All collision arithmetic is done one bit wider than a coordinate so nothing wraps.
package ball_motion_pkg;
  localparam int COORD_W    = 10;
  localparam int CMP_W      = COORD_W + 1;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int BALL_SIZE  = 8;
  localparam int PADDLE_W   = 8;
  localparam int PADDLE_H   = 64;
  localparam int PADDLE_L_X = 16;
  localparam int PADDLE_R_X = 616;
  localparam int STEP       = 1;
  localparam int X_CENTRE   = (H_ACTIVE - BALL_SIZE) / 2;
  localparam int Y_CENTRE   = (V_ACTIVE - BALL_SIZE) / 2;
  localparam int L_FACE     = PADDLE_L_X + PADDLE_W;
  localparam int R_FACE     = PADDLE_R_X - BALL_SIZE;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [CMP_W-1:0]   wide_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_MISS = 2'd2
  } state_e;

  function automatic wide_t widen(input coord_t v);
    return {1'b0, v};
  endfunction

  function automatic wide_t wc(input int v);
    return wide_t'(v);
  endfunction
endpackage

// File: rtl/ball_motion_if.sv
// Ball engine bus: divided clock, serve and paddle positions in; ball state and miss pulses out.
interface ball_motion_if;
  import ball_motion_pkg::*;

  logic   ball_clk;
  logic   serve;
  coord_t paddle_l_y;
  coord_t paddle_r_y;
  coord_t ball_x;
  coord_t ball_y;
  logic   ball_active;
  logic   miss_l;
  logic   miss_r;

  modport master (
    output ball_clk, serve, paddle_l_y, paddle_r_y,
    input  ball_x, ball_y, ball_active, miss_l, miss_r
  );

  modport slave (
    input  ball_clk, serve, paddle_l_y, paddle_r_y,
    output ball_x, ball_y, ball_active, miss_l, miss_r
  );
endinterface

// File: rtl/ball_motion_tick_sync.sv
// Brings the divided ball clock in as data and turns each rising edge into a
// one-cycle step pulse, registered on the third system clock edge after the rise.
module ball_motion_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic step
);
  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic step_q, step_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
    step_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      step_q <= step_d;
    end
  end

  assign step = step_q;
endmodule

// File: rtl/ball_motion.sv
// Pong ball position engine: serve / move / miss FSM advancing the ball one step
// per ball_clk rising edge, with wall and paddle bounces and per-side miss pulses.
module ball_motion
  import ball_motion_pkg::*;
#(
  parameter int SERVE_TICKS = 60
) (
  input  logic         clock_in,
  input  logic         reset,
  ball_motion_if.slave bus
);
  localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_TICKS - 1);

  logic             step;
  state_e           state_q, state_d;
  coord_t           x_q, x_d, y_q, y_d;
  logic             dx_q, dx_d, dy_q, dy_d;  // 1 = moving right / down
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             miss_l_q, miss_l_d, miss_r_q, miss_r_d;
  wide_t            x_w, y_w, pl_w, pr_w;
  logic             hit_l, hit_r, out_l, out_r;

  ball_motion_tick_sync u_tick (
    .clk  (clock_in),
    .rst  (reset),
    .din  (bus.ball_clk),
    .step (step)
  );

  assign x_w  = widen(x_q);
  assign y_w  = widen(y_q);
  assign pl_w = widen(bus.paddle_l_y);
  assign pr_w = widen(bus.paddle_r_y);

  // Paddle contact: ball is at or within one step of the paddle face and overlaps it vertically.
  assign hit_l = !dx_q
              && (x_w >= wc(L_FACE)) && (x_w - wc(STEP) <= wc(L_FACE))
              && (y_w + wc(BALL_SIZE) > pl_w) && (y_w < pl_w + wc(PADDLE_H));
  assign hit_r = dx_q
              && (x_w <= wc(R_FACE)) && (x_w + wc(STEP) >= wc(R_FACE))
              && (y_w + wc(BALL_SIZE) > pr_w) && (y_w < pr_w + wc(PADDLE_H));
  assign out_l = !dx_q && (x_w < wc(STEP));
  assign out_r = dx_q && (x_w + wc(BALL_SIZE + STEP) >= wc(H_ACTIVE));

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    cnt_d    = cnt_q;
    miss_l_d = 1'b0;
    miss_r_d = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.serve) state_d = ST_MOVE;
      ST_MOVE: if (step) begin
        if (!dy_q && (y_w < wc(STEP))) begin
          y_d  = '0;
          dy_d = 1'b1;
        end else if (dy_q && (y_w + wc(BALL_SIZE + STEP) >= wc(V_ACTIVE))) begin
          y_d  = coord_t'(V_ACTIVE - BALL_SIZE);
          dy_d = 1'b0;
        end else begin
          y_d  = dy_q ? coord_t'(y_w + wc(STEP)) : coord_t'(y_w - wc(STEP));
        end

        if (hit_l) begin
          x_d  = coord_t'(L_FACE);
          dx_d = 1'b1;
        end else if (hit_r) begin
          x_d  = coord_t'(R_FACE);
          dx_d = 1'b0;
        end else if (out_l) begin
          x_d      = '0;
          miss_l_d = 1'b1;
          state_d  = ST_MISS;
        end else if (out_r) begin
          x_d      = coord_t'(H_ACTIVE - BALL_SIZE);
          miss_r_d = 1'b1;
          state_d  = ST_MISS;
        end else begin
          x_d = dx_q ? coord_t'(x_w + wc(STEP)) : coord_t'(x_w - wc(STEP));
        end
      end
      // Direction survives the recentre so the next serve heads the same way.
      ST_MISS: if (step) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          x_d     = coord_t'(X_CENTRE);
          y_d     = coord_t'(Y_CENTRE);
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d == ST_MOVE);
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= coord_t'(X_CENTRE);
      y_q      <= coord_t'(Y_CENTRE);
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      cnt_q    <= '0;
      active_q <= 1'b0;
      miss_l_q <= 1'b0;
      miss_r_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      miss_l_q <= miss_l_d;
      miss_r_q <= miss_r_d;
    end
  end

  assign bus.ball_x      = x_q;
  assign bus.ball_y      = y_q;
  assign bus.ball_active = active_q;
  assign bus.miss_l      = miss_l_q;
  assign bus.miss_r      = miss_r_q;
endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: arithmetic ball model checked every cycle, plus directed
// literal checks for serve, wall bounce, paddle hit, miss/recentre, reset and stuck clock.
module tb_ball_motion;
  localparam int ST = 4;

  logic clock_in = 1'b0;
  logic reset    = 1'b1;
  ball_motion_if bus ();

  ball_motion #(.SERVE_TICKS(ST)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock_in = ~clock_in;

  int tests = 0;
  int fails = 0;

  // 0: free-running clock_in/8, 1: held low, 2: held high
  int bc_mode = 0;

  // model state
  int mx, my, mdx, mdy, mst, mcnt, mml, mmr;
  int h1, h2, h3, h4;
  int steps_taken = 0;
  int lhits = 0;
  int rhits = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timed_out(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    mx = 316; my = 236; mdx = 1; mdy = 1;
    mst = 0; mcnt = 0; mml = 0; mmr = 0;
    h1 = 0; h2 = 0; h3 = 0; h4 = 0;
  endtask

  // One system clock edge. A step is applied on the edge three edges after the
  // edge that first sampled ball_clk high.
  task automatic model_edge();
    int  ny, ndy, pl, pr;
    bit  do_step, hl, hr;
    do_step = (h3 != 0) && (h4 == 0);
    h4 = h3; h3 = h2; h2 = h1; h1 = int'(bus.ball_clk);
    pl = int'(bus.paddle_l_y);
    pr = int'(bus.paddle_r_y);
    mml = 0; mmr = 0;
    case (mst)
      0: if (bus.serve) mst = 1;
      1: if (do_step) begin
        steps_taken++;
        ndy = mdy;
        if (mdy < 0 && my < 1) begin ny = 0; ndy = 1; end
        else if (mdy > 0 && my + 8 + 1 >= 480) begin ny = 472; ndy = -1; end
        else ny = my + mdy;
        hl = (mdx < 0) && (mx >= 24) && (mx - 1 <= 24) && (my + 8 > pl) && (my < pl + 64);
        hr = (mdx > 0) && (mx + 8 <= 616) && (mx + 8 + 1 >= 616) && (my + 8 > pr) && (my < pr + 64);
        if (hl) begin mx = 24; mdx = 1; lhits++; end
        else if (hr) begin mx = 608; mdx = -1; rhits++; end
        else if (mdx < 0 && mx < 1) begin mx = 0; mml = 1; mst = 2; end
        else if (mdx > 0 && mx + 9 >= 640) begin mx = 632; mmr = 1; mst = 2; end
        else mx = mx + mdx;
        my = ny; mdy = ndy;
      end
      2: if (do_step) begin
        mcnt++;
        if (mcnt == ST) begin mcnt = 0; mx = 316; my = 236; mst = 0; end
      end
      default: mst = 0;
    endcase
  endtask

  // ball_clk source
  initial begin
    int cnt;
    cnt = 0;
    bus.ball_clk = 1'b0;
    forever begin
      @(negedge clock_in);
      cnt++;
      bus.ball_clk = (bc_mode == 2) || (bc_mode == 0 && (cnt % 8) < 4);
    end
  end

  // model + per-cycle compare
  initial begin
    model_reset();
    forever begin
      @(posedge clock_in);
      if (reset) model_reset();
      else model_edge();
      #1;
      if (!reset) begin
        chk("ball_x", int'(bus.ball_x), mx);
        chk("ball_y", int'(bus.ball_y), my);
        chk("ball_active", int'(bus.ball_active), (mst == 1) ? 1 : 0);
        chk("miss_l", int'(bus.miss_l), mml);
        chk("miss_r", int'(bus.miss_r), mmr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nm, s0, i;
    bus.serve      = 1'b0;
    bus.paddle_l_y = 10'd200;
    bus.paddle_r_y = 10'd200;
    repeat (3) @(negedge clock_in);
    reset = 1'b0;

    // idle: ball parked at centre, no pulses
    nm = 0;
    repeat (100) begin
      @(negedge clock_in);
      if (bus.miss_l || bus.miss_r) nm++;
    end
    chk("idle_x", int'(bus.ball_x), 316);
    chk("idle_y", int'(bus.ball_y), 236);
    chk("idle_active", int'(bus.ball_active), 0);
    chk("idle_miss", nm, 0);

    // serve, first three steps
    bus.paddle_l_y = 10'd150;
    bus.paddle_r_y = 10'd400;
    bus.serve = 1'b1;
    @(negedge clock_in);
    bus.serve = 1'b0;
    for (i = 0; i < 200 && steps_taken < 3; i++) @(negedge clock_in);
    if (steps_taken < 3) timed_out("serve_steps");
    chk("serve_x", int'(bus.ball_x), 319);
    chk("serve_y", int'(bus.ball_y), 239);
    chk("serve_active", int'(bus.ball_active), 1);

    // bottom wall bounce
    for (i = 0; i < 4000 && !(mst == 1 && my == 471 && mdy > 0); i++) @(negedge clock_in);
    if (!(my == 471 && mdy > 0)) timed_out("bottom_approach");
    chk("bottom_pre_y", int'(bus.ball_y), 471);
    s0 = steps_taken;
    for (i = 0; i < 40 && steps_taken == s0; i++) @(negedge clock_in);
    chk("bottom_y", int'(bus.ball_y), 472);
    chk("bottom_x", int'(bus.ball_x), 552);
    s0 = steps_taken;
    for (i = 0; i < 40 && steps_taken == s0; i++) @(negedge clock_in);
    chk("bottom_post_y", int'(bus.ball_y), 471);

    // right paddle return, then left paddle hit
    for (i = 0; i < 20000 && lhits == 0 && mst == 1; i++) @(negedge clock_in);
    if (lhits == 0) timed_out("left_hit");
    chk("lhit_x", int'(bus.ball_x), 24);
    chk("lhit_y", int'(bus.ball_y), 167);
    chk("lhit_miss_l", int'(bus.miss_l), 0);
    chk("lhit_active", int'(bus.ball_active), 1);

    // second rally: right hit again, then a left miss
    bus.paddle_r_y = 10'd170;
    bus.paddle_l_y = 10'd300;
    for (i = 0; i < 20000 && !bus.miss_l; i++) @(negedge clock_in);
    if (!bus.miss_l) timed_out("left_miss");
    chk("miss_x", int'(bus.ball_x), 0);
    chk("miss_active", int'(bus.ball_active), 0);
    @(negedge clock_in);
    chk("miss_pulse_width", int'(bus.miss_l), 0);
    for (i = 0; i < 200 && mst != 0; i++) @(negedge clock_in);
    if (mst != 0) timed_out("recentre");
    chk("recentre_x", int'(bus.ball_x), 316);
    chk("recentre_y", int'(bus.ball_y), 236);
    chk("recentre_active", int'(bus.ball_active), 0);

    // reset in the middle of a rally
    bus.serve = 1'b1;
    @(negedge clock_in);
    bus.serve = 1'b0;
    s0 = steps_taken;
    for (i = 0; i < 400 && steps_taken < s0 + 20; i++) @(negedge clock_in);
    chk("pre_reset_active", int'(bus.ball_active), 1);
    bc_mode = 1;
    reset = 1'b1;
    #1;
    chk("rst_x", int'(bus.ball_x), 316);
    chk("rst_y", int'(bus.ball_y), 236);
    chk("rst_active", int'(bus.ball_active), 0);
    chk("rst_miss", int'(bus.miss_l) + int'(bus.miss_r), 0);
    repeat (3) @(negedge clock_in);
    reset = 1'b0;

    // ball_clk stuck high: one step, three-edge lag
    repeat (4) @(negedge clock_in);
    bus.serve = 1'b1;
    @(negedge clock_in);
    bus.serve = 1'b0;
    repeat (2) @(negedge clock_in);
    @(posedge clock_in);
    #1 bc_mode = 2;
    repeat (3) @(posedge clock_in);
    #1;
    chk("lag_hold_x", int'(bus.ball_x), 316);
    @(posedge clock_in);
    #1;
    chk("lag_step_x", int'(bus.ball_x), 317);
    chk("lag_step_y", int'(bus.ball_y), 237);
    repeat (100) @(negedge clock_in);
    chk("stuck_x", int'(bus.ball_x), 317);
    chk("stuck_y", int'(bus.ball_y), 237);
    chk("stuck_active", int'(bus.ball_active), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
